dmem_access_ctrl: RTL

- Initiator side of the word-wide, registered-I/O data memory in the pipelined CPU.
- Sits in the MEM stage and turns pipeline load/store requests (byte, half, word) into word-only memory transactions.
- Memory has no byte enables, so sub-word stores are done as read-modify-write.
- Stalls the pipeline with `busy` and returns aligned, sign- or zero-extended load data with a one-cycle `resp_valid` pulse.

---
 rtl/dmem_access_ctrl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage initiator for a word-wide data memory with registered
// address and registered read data. Converts byte/half/word loads and stores into
// word-only transactions. Sub-word stores are done as read-modify-write.
//
// Ports:
//   clk, clrn             clock, asynchronous active-low reset
//   req_valid/we/size/unsigned/addr/wdata   pipeline request
//   busy                  pipeline stall
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load data (0 for stores)
//   misalign              one-cycle alignment/size fault pulse
//   mem_we/addr/wdata     memory command
//   mem_rdata             memory read data, valid RD_LAT cycles after mem_addr
//
// Optional feature macro: DMEM_LOAD_BYPASS_EN
//   Keeps a one-entry buffer of the last written word. Loads that hit it complete
//   without a memory read, and sub-word stores that hit it merge into the buffered word.

module dmem_access_ctrl #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              store_q, store_d;
    logic [31:0]       wdata_q, wdata_d;   // request store data
    logic [31:0]       wword_q, wword_d;   // full word to write
    logic [31:0]       rdata_q, rdata_d;   // extended load result

    logic              fault;
    logic              accept;
    logic              byp_hit;
    logic [31:0]       byp_word;

    // Select the addressed lane and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the store data onto the addressed lane(s) of an existing word.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] data,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r[{lane, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (lane[1]) r[31:16] = data[15:0];
                else         r[15:0]  = data[15:0];
            end
            default: r = data;
        endcase
        return r;
    endfunction

    always_comb begin
        case (req_size)
            2'b00:   fault = 1'b0;
            2'b01:   fault = req_addr[0];
            2'b10:   fault = |req_addr[1:0];
            default: fault = 1'b1;
        endcase
    end

    assign accept = (state_q == StIdle) && req_valid && !fault;

`ifdef DMEM_LOAD_BYPASS_EN
    logic        byp_valid_q;
    logic [29:0] byp_addr_q;
    logic [31:0] byp_data_q;

    assign byp_hit  = byp_valid_q && (byp_addr_q == req_addr[31:2]);
    assign byp_word = byp_data_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            byp_valid_q <= 1'b0;
            byp_addr_q  <= '0;
            byp_data_q  <= '0;
        end else if (state_q == StWrite) begin
            byp_valid_q <= 1'b1;
            byp_addr_q  <= addr_q[31:2];
            byp_data_q  <= wword_q;
        end
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_word = '0;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            store_q <= store_d;
            wdata_q <= wdata_d;
            wword_q <= wword_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        store_d    = store_q;
        wdata_d    = wdata_q;
        wword_d    = wword_q;
        rdata_d    = rdata_q;
        busy       = 1'b0;
        resp_valid = 1'b0;
        misalign   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (fault) begin
                        misalign = 1'b1;
                    end else begin
                        busy    = 1'b1;
                        addr_d  = req_addr;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        store_d = req_we;
                        wdata_d = req_wdata;
                        rdata_d = '0;
                        if (req_we && (req_size == 2'b10)) begin
                            wword_d = req_wdata;
                            state_d = StWrite;
                        end else if (byp_hit) begin
                            if (req_we) begin
                                wword_d = store_merge(byp_word, req_wdata, req_addr[1:0],
                                                      req_size);
                                state_d = StWrite;
                            end else begin
                                rdata_d = load_extend(byp_word, req_addr[1:0], req_size,
                                                      req_unsigned);
                                state_d = StResp;
                            end
                        end else begin
                            cnt_d   = CNT_W'(RD_LAT);
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: begin
                busy  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                // Address went out in the accept cycle, so read data is valid now.
                if (cnt_q == CNT_W'(1)) begin
                    if (store_q) begin
                        wword_d = store_merge(mem_rdata, wdata_q, addr_q[1:0], size_q);
                        state_d = StWrite;
                    end else begin
                        rdata_d = load_extend(mem_rdata, addr_q[1:0], size_q, uns_q);
                        state_d = StResp;
                    end
                end
            end
            StWrite: begin
                busy    = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                resp_valid = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Write strobe comes from registered state only so reset removes it asynchronously.
    assign mem_we     = (state_q == StWrite);
    assign mem_wdata  = mem_we ? wword_q : '0;
    // Present the address in the accept cycle so the read completes RD_LAT cycles later.
    assign mem_addr   = accept ? {req_addr[31:2], 2'b00} : {addr_q[31:2], 2'b00};
    assign resp_rdata = (state_q == StResp) ? rdata_q : '0;

endmodule
